// File: rtl/spi_command_sequencer_if.sv
// Bus bundle between the SPI command sequencer and its surroundings:
// the byte shifter (rx/tx), the SDRAM write port, the key matrix and CPU control.
// The master modport is the sequencer side; slave is the host/memory side.
interface spi_command_sequencer_if #(
  parameter int BANK_BITS = 9,
  parameter int KEY_ROWS  = 16
);
  localparam int KEY_Y_W = $clog2(KEY_ROWS);

  logic                   spi_cs_n;
  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic [7:0]             tx_data;
  logic                   sdram_ready;
  logic                   mem_req;
  logic                   mem_ack;
  logic [BANK_BITS+13:0]  mem_address;
  logic [7:0]             mem_wdata;
  logic                   key_we;
  logic [KEY_Y_W-1:0]     key_y;
  logic [7:0]             key_x;
  logic                   cpu_reset_n;
  logic                   cpu_run;

  modport master (
    input  spi_cs_n, rx_valid, rx_data, sdram_ready, mem_ack,
    output tx_data, mem_req, mem_address, mem_wdata, key_we, key_y, key_x,
           cpu_reset_n, cpu_run
  );

  modport slave (
    output spi_cs_n, rx_valid, rx_data, sdram_ready, mem_ack,
    input  tx_data, mem_req, mem_address, mem_wdata, key_we, key_y, key_x,
           cpu_reset_n, cpu_run
  );
endinterface

// File: rtl/spi_command_sequencer.sv
// SPI command sequencer: decodes host command frames (one byte per rx_valid,
// framed by spi_cs_n), streams image bytes into SDRAM through a req/ack
// handshake, writes key matrix rows, reports status and releases the CPU.
// Optional build macro SPI_SEQ_FILL_EN adds opcode 08h, a hardware zero-fill
// of one 16 KiB bank; without it 08h is treated as an unknown opcode.
module spi_command_sequencer #(
  parameter logic [7:0] ACK_BYTE  = 8'hA5,
  parameter int         BANK_BITS = 9,
  parameter int         KEY_ROWS  = 16
) (
  input logic clk,
  input logic reset,
  spi_command_sequencer_if.master bus
);
  localparam int KEY_Y_W = $clog2(KEY_ROWS);
  localparam int ADDR_W  = BANK_BITS + 14;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_ARG1,
    ST_ARG2,
    ST_DATA,
    ST_IGNORE
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           opcode_reg, opcode_next;
  logic [7:0]           tx_reg, tx_next;
  logic                 mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [7:0]           wdata_reg, wdata_next;
  logic                 key_we_reg, key_we_next;
  logic [KEY_Y_W-1:0]   key_y_reg, key_y_next;
  logic [7:0]           key_x_reg, key_x_next;
  logic                 reset_n_reg, reset_n_next;
  logic                 run_reg, run_next;
  logic [BANK_BITS-1:0] bank_reg, bank_next;
  logic [13:0]          offset_reg, offset_next;
  logic                 overrun_reg, overrun_next;
  logic                 busy;
`ifdef SPI_SEQ_FILL_EN
  logic                 fill_reg, fill_next;
`endif

`ifdef SPI_SEQ_FILL_EN
  assign busy = !bus.sdram_ready | mem_req_reg | fill_reg;
`else
  assign busy = !bus.sdram_ready | mem_req_reg;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_OPCODE;
    else       state_reg <= state_next;
  end

  // Datapath registers: command arguments, memory request, key and CPU control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_reg  <= 8'h00;
      tx_reg      <= ACK_BYTE;
      mem_req_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= 8'h00;
      key_we_reg  <= 1'b0;
      key_y_reg   <= '0;
      key_x_reg   <= 8'h00;
      reset_n_reg <= 1'b0;
      run_reg     <= 1'b0;
      bank_reg    <= '0;
      offset_reg  <= 14'h0000;
      overrun_reg <= 1'b0;
`ifdef SPI_SEQ_FILL_EN
      fill_reg    <= 1'b0;
`endif
    end else begin
      opcode_reg  <= opcode_next;
      tx_reg      <= tx_next;
      mem_req_reg <= mem_req_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      key_we_reg  <= key_we_next;
      key_y_reg   <= key_y_next;
      key_x_reg   <= key_x_next;
      reset_n_reg <= reset_n_next;
      run_reg     <= run_next;
      bank_reg    <= bank_next;
      offset_reg  <= offset_next;
      overrun_reg <= overrun_next;
`ifdef SPI_SEQ_FILL_EN
      fill_reg    <= fill_next;
`endif
    end
  end

  // Next-state and next-output decode for the command frame
  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    tx_next      = tx_reg;
    mem_req_next = mem_req_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    key_we_next  = 1'b0;
    key_y_next   = key_y_reg;
    key_x_next   = key_x_reg;
    reset_n_next = reset_n_reg;
    run_next     = run_reg;
    bank_next    = bank_reg;
    offset_next  = offset_reg;
    overrun_next = overrun_reg;
`ifdef SPI_SEQ_FILL_EN
    fill_next    = fill_reg;
`endif

    // An accepted write retires; a new request below may re-arm it this cycle.
    if (bus.mem_ack) mem_req_next = 1'b0;

    if (bus.spi_cs_n) begin
      // Frame end never cancels an outstanding write, only the decoder.
      state_next = ST_OPCODE;
      tx_next    = ACK_BYTE;
    end else if (bus.rx_valid) begin
      unique case (state_reg)
        ST_OPCODE: begin
          opcode_next = bus.rx_data;
          state_next  = ST_IGNORE;
          case (bus.rx_data)
            8'h02: run_next = 1'b1;
            8'h03, 8'h04, 8'h07: state_next = ST_ARG1;
            8'h05: begin
              // Status reflects the pre-clear overrun; reading it clears it.
              tx_next      = {5'b00000, run_reg, overrun_reg, busy};
              overrun_next = 1'b0;
            end
            8'h06: reset_n_next = 1'b1;
`ifdef SPI_SEQ_FILL_EN
            8'h08: state_next = ST_ARG1;
`endif
            default: ;
          endcase
`ifdef SPI_SEQ_FILL_EN
          // Anything that would touch memory or keys collides with a fill.
          if (fill_reg && (bus.rx_data == 8'h03 || bus.rx_data == 8'h04 ||
                           bus.rx_data == 8'h08)) begin
            state_next   = ST_IGNORE;
            overrun_next = 1'b1;
          end
`endif
        end
        ST_ARG1: begin
          state_next = ST_IGNORE;
          case (opcode_reg)
            8'h03: begin
              key_y_next = bus.rx_data[KEY_Y_W-1:0];
              state_next = ST_ARG2;
            end
            8'h04: begin
              bank_next[7:0] = bus.rx_data;
              offset_next    = 14'h0000;
              state_next     = ST_DATA;
            end
            8'h07: bank_next[BANK_BITS-1] = bus.rx_data[0];
`ifdef SPI_SEQ_FILL_EN
            8'h08: begin
              bank_next[7:0] = bus.rx_data;
              offset_next    = 14'h0000;
              fill_next      = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        ST_ARG2: begin
          key_x_next  = bus.rx_data;
          key_we_next = 1'b1;
          state_next  = ST_IGNORE;
        end
        ST_DATA: begin
          if (!mem_req_reg || bus.mem_ack) begin
            mem_req_next = 1'b1;
            addr_next    = {bank_reg, offset_reg};
            wdata_next   = bus.rx_data;
          end else begin
            overrun_next = 1'b1;
          end
          // The slot is consumed even when the byte is dropped.
          offset_next = offset_reg + 14'd1;
        end
        ST_IGNORE: ;
        default: state_next = ST_OPCODE;
      endcase
    end

`ifdef SPI_SEQ_FILL_EN
    // Zero-fill issues back-to-back requests whenever the port is free.
    if (fill_reg && (!mem_req_reg || bus.mem_ack)) begin
      mem_req_next = 1'b1;
      addr_next    = {bank_reg, offset_reg};
      wdata_next   = 8'h00;
      offset_next  = offset_reg + 14'd1;
      if (offset_reg == 14'h3FFF) fill_next = 1'b0;
    end
`endif
  end

  assign bus.tx_data     = tx_reg;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_address = addr_reg;
  assign bus.mem_wdata   = wdata_reg;
  assign bus.key_we      = key_we_reg;
  assign bus.key_y       = key_y_reg;
  assign bus.key_x       = key_x_reg;
  assign bus.cpu_reset_n = reset_n_reg;
  assign bus.cpu_run     = run_reg;
endmodule
